// File: rtl/uart_rx_mon.sv
// ---------------------------------------------------------------------------
// uart_rx_mon : UART receiver with a show-ahead receive FIFO.
//
// The serial line is synchronized, each frame is sampled mid-bit, and every
// received character is queued together with its parity and framing error
// flags. The consumer pops the head entry with a valid/ready handshake.
//
// Optional feature macro: UART_RX_BREAK_DETECT_EN
//   defined   : an all-zero frame (data, parity sample, stop sample) is not
//               queued; break_o pulses for one cycle and the receiver waits
//               for the line to return high before looking for a new start.
//   undefined : break_o is tied low and such a frame is queued with ferr=1.
//
// Ports
//   wb_clk_i       in   clock, rising edge
//   wb_rst_i       in   asynchronous active-high reset
//   rx_i           in   serial line (asynchronous, idle high)
//   rd_ready_i     in   consumer accepts the head entry
//   clr_overrun_i  in   clears the sticky overrun flag
//   rd_valid_o     out  FIFO non-empty, head entry valid
//   rd_data_o      out  head character, LSB = first received bit
//   rd_perr_o      out  head character parity error
//   rd_ferr_o      out  head character framing error
//   fifo_count_o   out  occupied FIFO entries
//   overrun_o      out  sticky: a character was dropped on a full FIFO
//   break_o        out  one-cycle break-detect pulse
// ---------------------------------------------------------------------------
module uart_rx_mon #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx_i,
  input  logic                          rd_ready_i,
  input  logic                          clr_overrun_i,
  output logic                          rd_valid_o,
  output logic [DATA_BITS-1:0]          rd_data_o,
  output logic                          rd_perr_o,
  output logic                          rd_ferr_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overrun_o,
  output logic                          break_o
);

`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                 state;
  logic                   rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr_reg;
  logic                   par_sample_reg;
  logic                   break_reg;

  logic                   tick_half, tick_bit;
  logic                   parity_exp;
  logic                   is_break;
  logic                   push;
  logic [EW-1:0]          wdata;

  // FIFO state
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [AW:0]            count;
  logic                   overrun_reg;
  logic                   pop, full, do_push, drop;
  logic [EW-1:0]          head;

  assign tick_half  = (cnt == HALF_LAST);
  assign tick_bit   = (cnt == BIT_LAST);
  // Expected parity bit value: odd mode makes the total number of ones odd.
  assign parity_exp = (PARITY == 1) ? ~^shreg : ^shreg;
  // Break frame: every sampled bit low, including the stop sample taken now.
  assign is_break   = BREAK_EN && (shreg == '0) &&
                      ((PARITY == 0) || !par_sample_reg) && !rx_sync;
  assign push       = (state == S_STOP) && tick_bit && !is_break;
  assign wdata      = {shreg, perr_reg, ~rx_sync};

  // Receive FSM, synchronizer and break pulse
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state          <= S_IDLE;
      rx_meta        <= 1'b1;
      rx_sync        <= 1'b1;
      rx_prev        <= 1'b1;
      cnt            <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      perr_reg       <= 1'b0;
      par_sample_reg <= 1'b0;
      break_reg      <= 1'b0;
    end else begin
      rx_meta   <= rx_i;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      break_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          bit_idx  <= '0;
          perr_reg <= 1'b0;
          // Only a true 1->0 transition starts a frame, so a line held low
          // after a frame cannot retrigger.
          if (rx_prev && !rx_sync) state <= S_START;
        end
        S_START: begin
          if (tick_half) begin
            cnt   <= '0;
            state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_bit) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
            if (bit_idx == DATA_LAST) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_bit) begin
            cnt            <= '0;
            par_sample_reg <= rx_sync;
            perr_reg       <= (rx_sync != parity_exp);
            state          <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_bit) begin
            cnt <= '0;
            if (is_break) begin
              break_reg <= 1'b1;
              state     <= S_WAIT_HIGH;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_sync) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Show-ahead FIFO control
  assign full    = (count == FULL_CNT);
  assign pop     = rd_valid_o && rd_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)               overrun_reg <= 1'b1;
      else if (clr_overrun_i) overrun_reg <= 1'b0;
    end
  end

  // Storage array carries no reset; outputs are gated by rd_valid_o instead.
  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head         = mem[rd_ptr];
  assign rd_valid_o   = (count != '0);
  assign rd_data_o    = rd_valid_o ? head[EW-1:2] : '0;
  assign rd_perr_o    = rd_valid_o && head[1];
  assign rd_ferr_o    = rd_valid_o && head[0];
  assign fifo_count_o = count;
  assign overrun_o    = overrun_reg;
  assign break_o      = break_reg;

endmodule

// File: tb/tb_uart_rx_mon.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_mon : self-checking bench for uart_rx_mon.
// One instance with default parameters (scoreboard-checked) and one with
// even parity (checked directly at the FIFO head).
// ---------------------------------------------------------------------------
module tb_uart_rx_mon;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx, rx_p;
  logic       rd_ready, rd_ready_p;
  logic       clr, clr_p;

  logic       rd_valid, rd_perr, rd_ferr, overrun, brk;
  logic [7:0] rd_data;
  logic [3:0] fifo_count;
  logic       rd_valid_p, rd_perr_p, rd_ferr_p, overrun_p, brk_p;
  logic [7:0] rd_data_p;
  logic [3:0] fifo_count_p;

  int checks = 0;
  int errors = 0;
  int brk_cnt = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  uart_rx_mon dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx), .rd_ready_i(rd_ready),
    .clr_overrun_i(clr), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .rd_perr_o(rd_perr), .rd_ferr_o(rd_ferr), .fifo_count_o(fifo_count),
    .overrun_o(overrun), .break_o(brk)
  );

  uart_rx_mon #(.PARITY(2)) dut_p (
    .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx_p), .rd_ready_i(rd_ready_p),
    .clr_overrun_i(clr_p), .rd_valid_o(rd_valid_p), .rd_data_o(rd_data_p),
    .rd_perr_o(rd_perr_p), .rd_ferr_o(rd_ferr_p), .fifo_count_o(fifo_count_p),
    .overrun_o(overrun_p), .break_o(brk_p)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry actual=%0h required=none", {rd_data, rd_perr, rd_ferr});
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        $display("RX data=%02h perr=%0b ferr=%0b (exp %02h %0b %0b)",
                 rd_data, rd_perr, rd_ferr, e[9:2], e[1], e[0]);
        chk("entry", {22'd0, rd_data, rd_perr, rd_ferr}, {22'd0, e});
      end
    end
  end

  always @(negedge clk) if (brk === 1'b1) brk_cnt++;

  // Drives one frame starting right after an active edge; reports the first
  // cycle (counted from the start-bit edge) at which rd_valid is seen high.
  task automatic send(input bit sel, input logic [7:0] data, input bit has_par,
                      input logic par, input logic stop, output int first_valid);
    int n;
    int cyc;
    logic b;
    n = has_par ? 11 : 10;
    cyc = 0;
    first_valid = -1;
    for (int i = 0; i < n; i++) begin
      if (i == 0)                 b = 1'b0;
      else if (i <= 8)            b = data[i-1];
      else if (has_par && i == 9) b = par;
      else                        b = stop;
      if (sel) rx_p = b; else rx = b;
      repeat (CPB) begin
        @(posedge clk); #1;
        cyc++;
        if (first_valid < 0 && (sel ? rd_valid_p : rd_valid)) first_valid = cyc;
      end
    end
    if (sel) rx_p = 1'b1; else rx = 1'b1;
    repeat (2 * CPB) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int fv;
    vecs[0] = '{8'h41, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'h0A, 1'b1, 8'h0A, 1'b0, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0};

    rst = 1'b1; rx = 1'b1; rx_p = 1'b1;
    rd_ready = 1'b1; rd_ready_p = 1'b0; clr = 1'b0; clr_p = 1'b0;
    idle(3);
    chk("rst_valid", {31'd0, rd_valid}, 0);
    chk("rst_data", {24'd0, rd_data}, 0);
    chk("rst_count", {28'd0, fifo_count}, 0);
    chk("rst_flags", {28'd0, rd_perr, rd_ferr, overrun, brk}, 0);
    rst = 1'b0;
    idle(4);

    // Short low glitch: no entry, receiver still usable afterwards.
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * CPB);
    chk("glitch_valid", {31'd0, rd_valid}, 0);
    chk("glitch_count", {28'd0, fifo_count}, 0);

    // Table-driven frames with latency window check.
    foreach (vecs[i]) begin
      sb.push_back({vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
      send(1'b0, vecs[i].data, 1'b0, 1'b0, vecs[i].stop, fv);
      checks++;
      if (fv < 9 * CPB + 1 || fv > 10 * CPB) begin
        errors++;
        $display("FAIL latency_%0d actual=%0d required=%0d..%0d", i, fv, 9 * CPB + 1, 10 * CPB);
      end
    end
    chk("table_drained", sb.size(), 0);

    // Line held low for 20 bit times.
    brk_cnt = 0;
`ifndef UART_RX_BREAK_DETECT_EN
    sb.push_back({8'h00, 1'b0, 1'b1});
`endif
    rx = 1'b0;
    idle(20 * CPB);
    rx = 1'b1;
    idle(3 * CPB);
`ifdef UART_RX_BREAK_DETECT_EN
    chk("break_pulses", brk_cnt, 1);
`else
    chk("break_pulses", brk_cnt, 0);
`endif
    chk("break_drained", sb.size(), 0);
    chk("break_count", {28'd0, fifo_count}, 0);

    // Even parity instance: checked at the FIFO head then popped.
    send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, fv);
    chk("p1_valid", {31'd0, rd_valid_p}, 1);
    chk("p1_data", {24'd0, rd_data_p}, 32'h03);
    chk("p1_perr", {31'd0, rd_perr_p}, 1);
    chk("p1_ferr", {31'd0, rd_ferr_p}, 0);
    rd_ready_p = 1'b1; idle(1); rd_ready_p = 1'b0;
    chk("p1_popped", {31'd0, rd_valid_p}, 0);
    send(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, fv);
    chk("p2_data", {24'd0, rd_data_p}, 32'h03);
    chk("p2_perr", {31'd0, rd_perr_p}, 0);
    rd_ready_p = 1'b1; idle(1); rd_ready_p = 1'b0;
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, fv);
    chk("p3_data", {24'd0, rd_data_p}, 32'h07);
    chk("p3_perr", {31'd0, rd_perr_p}, 0);
    rd_ready_p = 1'b1; idle(1); rd_ready_p = 1'b0;
    chk("p_count", {28'd0, fifo_count_p}, 0);

    // Overrun: nine characters into the eight-entry FIFO with no reads.
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back({i[7:0], 1'b0, 1'b0});
      send(1'b0, i[7:0], 1'b0, 1'b0, 1'b1, fv);
    end
    chk("ovr_count", {28'd0, fifo_count}, 8);
    chk("ovr_flag", {31'd0, overrun}, 1);
    chk("ovr_head", {24'd0, rd_data}, 0);
    clr = 1'b1; idle(1); clr = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 0);
    rd_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() != 0; k++) idle(1);
    chk("ovr_drained", sb.size(), 0);
    chk("ovr_count_end", {28'd0, fifo_count}, 0);

    // Reset mid-character with three entries queued.
    rd_ready = 1'b0;
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, fv);
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, fv);
    send(1'b0, 8'h33, 1'b0, 1'b0, 1'b1, fv);
    chk("pre_rst_count", {28'd0, fifo_count}, 3);
    rx = 1'b0;
    idle(40);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, rd_valid}, 0);
    chk("arst_data", {24'd0, rd_data}, 0);
    chk("arst_count", {28'd0, fifo_count}, 0);
    chk("arst_flags", {28'd0, rd_perr, rd_ferr, overrun, brk}, 0);
    rx = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    rd_ready = 1'b1;
    sb.push_back({8'h7E, 1'b0, 1'b0});
    send(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, fv);
    idle(4);
    chk("final_drained", sb.size(), 0);
    chk("final_count", {28'd0, fifo_count}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_mon.md
UART_RX_MON -- requirements
Module: uart_rx_mon

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit (>=4, even).
REQ-002 Parameter DATA_BITS, default 8, data bits per character (5..8).
REQ-003 Parameter PARITY, default 0, parity mode (0 none, 1 odd, 2 even).
REQ-004 Parameter FIFO_DEPTH, default 8, receive FIFO entries (power of 2, 2..64).
REQ-005 wb_clk_i  input  1  single clock; all logic on rising edge.
REQ-006 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-007 rx_i  input  1  serial line, asynchronous, idle high.
REQ-008 rd_ready_i  input  1  consumer accepts head entry.
REQ-009 clr_overrun_i  input  1  clears sticky overrun flag.
REQ-010 rd_valid_o  output  1  FIFO non-empty; head entry valid.
REQ-011 rd_data_o  output  DATA_BITS  head character, LSB = first received bit.
REQ-012 rd_perr_o  output  1  head character parity error (0 when PARITY=0).
REQ-013 rd_ferr_o  output  1  head character framing error.
REQ-014 fifo_count_o  output  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-015 overrun_o  output  1  sticky: character dropped on full FIFO.
REQ-016 break_o  output  1  one-cycle break-detect pulse.

Function
REQ-017 rx_i SHALL pass a 2-flop synchronizer (reset value 1); all detection uses the synchronized value.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-019 IDLE->START on synchronized falling edge (prev 1, cur 0) only; a held-low line SHALL NOT retrigger.
REQ-020 START: sample after CLKS_PER_BIT/2 cycles; if high -> IDLE (glitch, nothing pushed), else -> DATA.
REQ-021 DATA: DATA_BITS samples, one every CLKS_PER_BIT cycles, shifted in LSB first; then PARITY if PARITY!=0, else STOP.
REQ-022 PARITY: one sample; perr = sample differs from odd/even parity of data bits.
REQ-023 STOP: one sample; ferr = sample low; push {data, perr, ferr}; -> IDLE, or WAIT_HIGH per REQ-031.
REQ-024 Pushed entry SHALL appear at rd_valid_o/rd_data_o on the cycle after the stop-bit sample (show-ahead FIFO).
REQ-025 Pop occurs when rd_valid_o && rd_ready_i; rd_ready_i with empty FIFO has no effect.
REQ-026 Push with FIFO full and no pop in the same cycle: character dropped, overrun_o set, FIFO contents unchanged.
REQ-027 Simultaneous push and pop when full: both performed, no overrun, count unchanged.
REQ-028 Simultaneous push and pop otherwise: count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-029 overrun_o cleared by clr_overrun_i; if set and clear coincide, set wins.

Reset
REQ-030 wb_rst_i SHALL asynchronously force: FSM IDLE, counters 0, synchronizer 1, FIFO empty, rd_valid_o 0, rd_data_o 0, rd_perr_o 0, rd_ferr_o 0, fifo_count_o 0, overrun_o 0, break_o 0; a character in progress is discarded.

Configuration
REQ-031 With UART_RX_BREAK_DETECT_EN defined: frame with all data bits 0, parity sample 0 (if present) and stop sample 0 SHALL not be pushed; break_o pulses one cycle; FSM -> WAIT_HIGH until synchronized rx_i is 1, then IDLE.
REQ-032 Without UART_RX_BREAK_DETECT_EN: break_o tied 0, WAIT_HIGH unreachable, such frames pushed with ferr=1, FSM -> IDLE.

Verification
REQ-033 Defaults; send 0x41 then 0x0A at 16 clk/bit -> two entries 0x41, 0x0A, perr=ferr=0, rd_valid_o one cycle after each stop sample.
REQ-034 PARITY=2; send 0x03 with parity bit 1 -> entry 0x03, rd_perr_o=1; with parity bit 0 -> rd_perr_o=0.
REQ-035 rd_ready_i=0; send 9 characters 0x00..0x08 to depth-8 FIFO -> fifo_count_o=8, overrun_o=1, entries 0x00..0x07; clr_overrun_i -> overrun_o=0.
REQ-036 rx_i low for 4 cycles then high -> no entry, FSM back in IDLE; stop bit driven low on 0x55 -> entry 0x55 with rd_ferr_o=1.
REQ-037 UART_RX_BREAK_DETECT_EN defined; hold rx_i low 20 bit times -> one break_o pulse, no entry, no further start until rx_i high; undefined -> one entry 0x00, ferr=1.
REQ-038 Assert wb_rst_i mid-character with 3 entries queued -> all outputs at reset values; next 0x7E received cleanly.
